// File: rtl/ram4k_loader_if.sv
// rtl/ram4k_loader_if.sv - byte-stream and RAM write bus shared by the loader and its neighbours
interface ram4k_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [DATA_W-1:0] ram_in;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_load;

  // Byte source side; also observes the RAM write bus.
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, ram_in, ram_address, ram_load
  );

  // Loader side: consumes bytes, drives the RAM write bus.
  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, ram_in, ram_address, ram_load
  );
endinterface

// File: rtl/ram4k_loader.sv
// rtl/ram4k_loader.sv - assembles big-endian words from a byte stream and fills consecutive RAM addresses
module ram4k_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  words_written_o,
  ram4k_loader_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, WRITE, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  written_q;
  logic [DATA_W-1:0] word_q;
  logic              byte_ready_q, ram_load_q, busy_q, done_q, error_q;
  logic              hs, count_ok;

  assign hs       = bus.byte_valid & byte_ready_q;
  assign count_ok = (word_count_i != '0) && (word_count_i <= MAX_WORDS);

  // Next-state decode; abort overrides any byte handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && count_ok) state_d = GET_HI;
      GET_HI:  if (abort_i) state_d = IDLE; else if (hs) state_d = GET_LO;
      GET_LO:  if (abort_i) state_d = IDLE; else if (hs) state_d = WRITE;
      WRITE:   if (abort_i) state_d = IDLE;
               else if (remaining_q == CNT_W'(1)) state_d = DONE;
               else state_d = GET_HI;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, registered strobes derived from the next state, and the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      written_q    <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      ram_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= (state_d == GET_HI) || (state_d == GET_LO);
      ram_load_q   <= (state_d == WRITE);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (count_ok) begin
              error_q     <= 1'b0;
              written_q   <= '0;
              ptr_q       <= base_addr_i;
              remaining_q <= word_count_i;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        GET_HI: if (hs && !abort_i) word_q[DATA_W-1:DATA_W-8] <= bus.byte_in;
        GET_LO: if (hs && !abort_i) word_q[7:0] <= bus.byte_in;
        // The write commits this cycle even if abort is raised alongside it.
        WRITE: begin
          ptr_q       <= ptr_q + ADDR_W'(1);
          remaining_q <= remaining_q - CNT_W'(1);
          written_q   <= written_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready  = byte_ready_q;
  assign bus.ram_load    = ram_load_q;
  assign bus.ram_address = ptr_q;
  assign bus.ram_in      = word_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign words_written_o = written_q;

endmodule

// File: tb/tb_ram4k_loader.sv
// tb/tb_ram4k_loader.sv - self-checking bench for ram4k_loader
module tb_ram4k_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] base = '0;
  logic [12:0] wcount = '0;
  logic        busy, done, error;
  logic [12:0] ww;

  ram4k_loader_if #(.ADDR_W(12), .DATA_W(16)) bus();

  ram4k_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .base_addr_i(base), .word_count_i(wcount),
    .busy_o(busy), .done_o(done), .error_o(error), .words_written_o(ww),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [11:0] obs_addr[$];
  logic [15:0] obs_data[$];
  int          obs_cyc[$];
  logic [7:0]  tx[$];
  logic [15:0] mem [0:4095];

  always @(posedge clk) cyc++;

  // Observe the RAM port and the done strobe mid-cycle; mem models the RAM block.
  always @(negedge clk) begin
    if (bus.ram_load === 1'b1) begin
      obs_addr.push_back(bus.ram_address);
      obs_data.push_back(bus.ram_in);
      obs_cyc.push_back(cyc);
      mem[bus.ram_address] = bus.ram_in;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic fill_tx(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
  endtask

  // Called at posedge+1; holds start for one cycle then scrambles the captured inputs.
  task automatic pulse_start(input logic [11:0] b, input logic [12:0] n);
    base = b; wcount = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = 12'($urandom); wcount = 13'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    repeat ($urandom_range(0, maxgap)) begin
      bus.byte_valid = 1'b0; bus.byte_in = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1; bus.byte_in = b; n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n >= 50) begin
      bad++; $display("FAIL byte_ready_timeout ready=%b want 1", bus.byte_ready);
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0; bus.byte_in = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n >= 300) begin bad++; $display("FAIL idle_timeout busy=%b want 0", busy); end
  endtask

  // Compare the observed writes against the words the byte list should produce.
  task automatic check_writes(input string nm, input logic [11:0] b, input int n);
    int m;
    logic [11:0] ea;
    logic [15:0] ed;
    total++;
    if (obs_addr.size() != n) begin
      bad++; $display("FAIL %s_count got=%0d want=%0d", nm, obs_addr.size(), n);
    end
    m = (obs_addr.size() < n) ? obs_addr.size() : n;
    for (int i = 0; i < m; i++) begin
      ea = 12'((int'(b) + i) % 4096);
      ed = tx[2*i] * 256 + tx[2*i+1];
      total++;
      if (obs_addr[i] !== ea || obs_data[i] !== ed) begin
        bad++; $display("FAIL %s_word%0d got=%h@%h want=%h@%h", nm, i, obs_data[i], obs_addr[i], ed, ea);
      end
      total++;
      if (mem[ea] !== ed) begin
        bad++; $display("FAIL %s_mem%0d got=%h want=%h", nm, i, mem[ea], ed);
      end
    end
  endtask

  task automatic run_load(input string nm, input logic [11:0] b, input int n, input int maxgap, input bit spacing);
    clear_obs();
    pulse_start(b, 13'(n));
    for (int i = 0; i < 2*n; i++) send_byte(tx[i], maxgap);
    wait_idle();
    check_writes(nm, b, n);
    if (spacing) begin
      for (int i = 1; i < obs_cyc.size(); i++) begin
        total++;
        if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
          bad++; $display("FAIL %s_spacing%0d got=%0d want=3", nm, i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL %s_done_pulses got=%0d want=1", nm, done_cnt); end
    if (obs_cyc.size() > 0) begin
      total++;
      if (done_cyc != obs_cyc[obs_cyc.size()-1] + 1) begin
        bad++; $display("FAIL %s_done_latency got=%0d want=%0d", nm, done_cyc, obs_cyc[obs_cyc.size()-1] + 1);
      end
    end
    total++;
    if (ww !== 13'(n) || error !== 1'b0) begin
      bad++; $display("FAIL %s_status ww=%0d err=%b want ww=%0d err=0", nm, ww, error, n);
    end
  endtask

  task automatic test_reset();
    #7;
    total++;
    if ({busy, done, error, bus.byte_ready, bus.ram_load} !== 5'b0 || bus.ram_in !== 16'h0 ||
        bus.ram_address !== 12'h0 || ww !== 13'h0) begin
      bad++; $display("FAIL reset_state busy=%b done=%b err=%b rdy=%b load=%b in=%h addr=%h ww=%0d want all 0",
                      busy, done, error, bus.byte_ready, bus.ram_load, bus.ram_in, bus.ram_address, ww);
    end
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midload();
    fill_tx(4);
    clear_obs();
    pulse_start(12'h3A0, 13'd2);
    send_byte(tx[0], 0);
    send_byte(tx[1], 0);
    total++;
    if (bus.ram_load !== 1'b1) begin bad++; $display("FAIL midreset_pre_load got=%b want 1", bus.ram_load); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, error, bus.byte_ready, bus.ram_load} !== 5'b0 || bus.ram_in !== 16'h0 ||
        bus.ram_address !== 12'h0 || ww !== 13'h0) begin
      bad++; $display("FAIL midreset_state busy=%b load=%b rdy=%b in=%h addr=%h ww=%0d want all 0",
                      busy, bus.ram_load, bus.byte_ready, bus.ram_in, bus.ram_address, ww);
    end
    @(negedge clk); #1;
    total++;
    if (obs_addr.size() != 0) begin bad++; $display("FAIL midreset_no_write got=%0d want=0", obs_addr.size()); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    tx.delete();
    tx.push_back(8'h12); tx.push_back(8'h34); tx.push_back(8'hAB);
    tx.push_back(8'hCD); tx.push_back(8'h00); tx.push_back(8'hFF);
    run_load("basic", 12'h010, 3, 0, 1'b1);
  endtask

  task automatic test_wrap();
    tx.delete();
    tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33); tx.push_back(8'h44);
    run_load("wrap", 12'hFFF, 2, 0, 1'b1);
  endtask

  task automatic test_illegal();
    logic [12:0] bad_counts[3];
    bad_counts[0] = 13'd0; bad_counts[1] = 13'd4097; bad_counts[2] = 13'h1FFF;
    clear_obs();
    foreach (bad_counts[k]) begin
      pulse_start(12'($urandom), bad_counts[k]);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (error !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL illegal_%0d err=%b busy=%b want err=1 busy=0", bad_counts[k], error, busy);
      end
    end
    total++;
    if (obs_addr.size() != 0 || done_cnt != 0) begin
      bad++; $display("FAIL illegal_no_write writes=%0d done=%0d want 0 0", obs_addr.size(), done_cnt);
    end
    pulse_start(12'h123, 13'd4096);
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL max_count_start err=%b busy=%b want err=0 busy=1", error, busy);
    end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    pulse_start(12'h0, 13'd0);
    fill_tx(2);
    run_load("legal_after_err", 12'($urandom), 1, 1, 1'b0);
  endtask

  task automatic test_backpressure_abort();
    fill_tx(4);
    run_load("gaps", 12'($urandom), 2, 4, 1'b0);
    fill_tx(2);
    clear_obs();
    pulse_start(12'h200, 13'd3);
    send_byte(tx[0], 2);
    bus.byte_valid = 1'b1; bus.byte_in = tx[1]; abort = 1'b1;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      bad++; $display("FAIL abort_next busy=%b rdy=%b want 0 0", busy, bus.byte_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (obs_addr.size() != 0 || done_cnt != 0 || ww !== 13'd0) begin
      bad++; $display("FAIL abort_effects writes=%0d done=%0d ww=%0d want 0 0 0", obs_addr.size(), done_cnt, ww);
    end
  endtask

  task automatic test_abort_in_write();
    logic [11:0] b;
    b = 12'($urandom);
    fill_tx(6);
    clear_obs();
    pulse_start(b, 13'd3);
    for (int i = 0; i < 4; i++) send_byte(tx[i], 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_write_busy got=%b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    check_writes("abort_write", b, 2);
    total++;
    if (ww !== 13'd2 || done_cnt != 0) begin
      bad++; $display("FAIL abort_write_status ww=%0d done=%0d want 2 0", ww, done_cnt);
    end
  endtask

  task automatic test_start_busy();
    logic [11:0] b;
    b = 12'($urandom);
    fill_tx(4);
    clear_obs();
    pulse_start(b, 13'd2);
    send_byte(tx[0], 0);
    pulse_start(b + 12'd100, 13'd5);
    for (int i = 1; i < 4; i++) send_byte(tx[i], 0);
    wait_idle();
    check_writes("start_busy", b, 2);
    total++;
    if (ww !== 13'd2 || done_cnt != 1) begin
      bad++; $display("FAIL start_busy_status ww=%0d done=%0d want 2 1", ww, done_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    logic [11:0] b;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 5);
      b = (it % 2 == 0) ? 12'($urandom_range(4092, 4095)) : 12'($urandom);
      fill_tx(2 * n);
      run_load("random", b, n, 3, 1'b0);
    end
  endtask

  initial begin
    bus.byte_in = 8'h0;
    bus.byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_illegal();
    test_backpressure_abort();
    test_abort_in_write();
    test_start_busy();
    test_random();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram4k_loader.md
Name: ram4k_loader

Overview:
- Upstream fill engine for the 4K-word, 16-bit RAM block.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them to consecutive RAM addresses from a programmable base.
- Used to preload program or data memory from a byte source such as a UART receiver, before the CPU runs.
- Drives the RAM's in/address/load inputs directly; the RAM write commits on the same clk edge at which ram_load is sampled high.

Parameters:
- ADDR_W, 12, RAM address width (4096 words).
- DATA_W, 16, RAM word width; must equal 2 × 8.
- CNT_W, 13, width of word_count and words_written (holds 0..4096).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle request to begin a load; sampled only in IDLE.
- abort  input  1  cancels a load in progress; has priority over byte handshake.
- base_addr  input  ADDR_W  first RAM address; captured on accepted start.
- word_count  input  CNT_W  number of words to write (valid range 1..4096); captured on accepted start.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- ram_in  output  DATA_W  word to write, to RAM in.
- ram_address  output  ADDR_W  write address, to RAM address.
- ram_load  output  1  write enable, to RAM load.
- busy  output  1  high in any state except IDLE.
- done  output  1  1-cycle pulse when all words have been written.
- error  output  1  sticky flag for an illegal word_count; cleared by the next accepted start.
- words_written  output  CNT_W  words committed since the last accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - byte_ready=0, ram_load=0, busy=0, done=0, error=0.
  - ram_in=0, ram_address=0, words_written=0.
- FSM states: IDLE, GET_HI, GET_LO, WRITE, DONE.
- IDLE, start=1:
  - If word_count is 0 or >4096: set error=1 and stay in IDLE; no writes occur.
  - Otherwise: clear error and words_written, load the address pointer with base_addr, load remaining with word_count, go to GET_HI.
- IDLE, start=0: hold state.
- GET_HI: byte_ready=1. On byte_valid&byte_ready, latch byte_in into ram_in[15:8] and go to GET_LO.
- GET_LO: byte_ready=1. On the handshake, latch byte_in into ram_in[7:0] and go to WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready=0; ram_load=1; ram_address = pointer; ram_in = assembled word.
  - At the end of the cycle: pointer += 1, wrapping 4095→0; remaining -= 1; words_written += 1.
  - If remaining reaches 0, go to DONE; otherwise go to GET_HI.
- DONE: done=1 for 1 cycle, then go to IDLE.
- ram_load is high only in WRITE. Outside WRITE, ram_address shows the pointer and ram_in holds its last value.
- Latency and throughput:
  - ram_load rises the cycle after the low-byte handshake.
  - Minimum 3 cycles per word with byte_valid held high.
  - done asserts the cycle after the last WRITE.
- Backpressure: byte_valid gaps stall GET_HI/GET_LO indefinitely with no timeout. byte_in is ignored while byte_ready=0.
- start while busy: ignored.
- abort while busy:
  - The next state is IDLE.
  - A partially assembled word is discarded and never written. If abort arrives in WRITE, that write still completes in the same cycle.
  - No done pulse is generated.
  - words_written retains the count of committed words.
- Simultaneous abort and byte handshake: abort wins and the byte is not consumed. byte_ready must be low in the cycle that follows.
- Reset mid-load: all outputs return to their reset values immediately, asynchronously. No ram_load glitch is permitted.

Test Plan:
- Reset: assert rst_n=0 mid-sim → all outputs at reset values within the same cycle; ram_load never high.
- Basic load: base_addr=0x010, word_count=3, bytes 12 34 AB CD 00 FF back-to-back → writes 0x1234@0x010, 0xABCD@0x011, 0x00FF@0x012, each WRITE 3 cycles apart; done for 1 cycle; words_written=3; RAM readback matches.
- Wrap: base_addr=0xFFF, word_count=2, bytes 11 22 33 44 → 0x1122@0xFFF, 0x3344@0x000.
- Illegal count: start with word_count=0, then with 4097 → error=1, busy=0, no ram_load. A following legal start clears error.
- Backpressure and abort: load 2 words with random byte_valid gaps → correct data regardless of gaps. Then start a new load, send one byte, assert abort → no write, busy=0 next cycle, no done.
- Start while busy: pulse start with a different base_addr during GET_LO → ignored; writes continue at the original addresses.
